// File: rtl/vram_pkg.sv
// Shared video-RAM definitions: reader FSM states, slot timing defaults, address width.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W    = 15;
  localparam int unsigned SLOT_LEN_DEF   = 4;
  localparam int unsigned SAMPLE_CYC_DEF = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    ACCESS    = 2'd2,
    HOLD      = 2'd3
  } vram_state_t;

endpackage

// File: rtl/sig_sync.sv
// Multi-flop synchronizer for asynchronous inputs; reset loads RST_VAL into every stage.
module sig_sync #(
  parameter int unsigned       WIDTH   = 1,
  parameter int unsigned       STAGES  = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) ff[i] <= RST_VAL;
    end else begin
      ff[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/vram_reader.sv
// CPU read port into video RAM: waits for a free video-timing slot, reads one byte, holds it for the CPU.
module vram_reader
  import vram_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SLOT_LEN    = SLOT_LEN_DEF,
  parameter int unsigned SAMPLE_CYC  = SAMPLE_CYC_DEF
) (
  input  logic                   CLK_50,
  input  logic                   RST,
  input  logic [VRAM_ADDR_W-1:0] CPU_A,
  input  logic                   CPU_nCS,
  input  logic                   CPU_nRD,
  output logic [7:0]             CPU_D_OUT,
  output logic                   CPU_D_OE,
  output logic                   CPU_nWAIT,
  input  logic                   SLOT,
  output logic                   RAM_REQ,
  output logic [VRAM_ADDR_W-1:0] RAM_A,
  input  logic [7:0]             RAM_D_IN,
  output logic                   RAM_nOE
);

  localparam int unsigned CNT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_CYC);

  vram_state_t            state, state_n;
  logic [CNT_W-1:0]       cnt;
  logic                   aborted;
  logic                   latch_addr;
  logic [VRAM_ADDR_W-1:0] addr_q;
  logic [7:0]             data_q;
  logic [1:0]             strobes;
  logic                   rd_act;

  sig_sync #(
    .WIDTH  (2),
    .STAGES (SYNC_STAGES),
    .RST_VAL(2'b11)
  ) u_sync (
    .clk(CLK_50),
    .rst(RST),
    .d  ({CPU_nCS, CPU_nRD}),
    .q  (strobes)
  );

  assign rd_act = ~strobes[1] & ~strobes[0];

  always_ff @(posedge CLK_50) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    latch_addr = 1'b0;
    case (state)
      IDLE: begin
        if (rd_act) begin
          state_n    = WAIT_SLOT;
          latch_addr = 1'b1;
        end
      end
      WAIT_SLOT: begin
        if (!rd_act)   state_n = IDLE;
        else if (SLOT) state_n = ACCESS;
      end
      ACCESS: begin
        // a release seen anywhere in the slot skips HOLD, but never cuts the slot short
        if (cnt == CNT_LAST) state_n = (aborted || !rd_act) ? IDLE : HOLD;
      end
      HOLD: begin
        if (!rd_act) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      cnt     <= '0;
      aborted <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      cnt <= (state == ACCESS && state_n == ACCESS) ? cnt + CNT_W'(1) : '0;
      if (state != ACCESS) aborted <= 1'b0;
      else if (!rd_act)    aborted <= 1'b1;
      if (latch_addr) addr_q <= CPU_A;
      if (state == ACCESS && cnt == CNT_SAMPLE) data_q <= RAM_D_IN;
    end
  end

  assign RAM_REQ   = (state == ACCESS);
  assign RAM_nOE   = ~RAM_REQ;
  assign RAM_A     = addr_q;
  assign CPU_nWAIT = ~((state == WAIT_SLOT) || (state == ACCESS));
  assign CPU_D_OE  = (state == HOLD);
  assign CPU_D_OUT = data_q;

endmodule

// File: tb/tb_vram_reader.sv
// Directed bench for vram_reader with an expected-data scoreboard.
module tb_vram_reader;

  logic        CLK_50 = 1'b0;
  logic        RST = 1'b1;
  logic [14:0] CPU_A = '0;
  logic        CPU_nCS = 1'b1;
  logic        CPU_nRD = 1'b1;
  logic [7:0]  CPU_D_OUT;
  logic        CPU_D_OE;
  logic        CPU_nWAIT;
  logic        SLOT = 1'b0;
  logic        RAM_REQ;
  logic [14:0] RAM_A;
  logic [7:0]  RAM_D_IN;
  logic        RAM_nOE;

  logic [7:0]  ram_d_drv = '0;
  logic        ram_model = 1'b0;
  logic        slot_auto = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb [$];

  function automatic logic [7:0] mem_f(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
  endfunction

  assign RAM_D_IN = ram_model ? mem_f(RAM_A) : ram_d_drv;

  always #10 CLK_50 = ~CLK_50;

  vram_reader #(.SYNC_STAGES(2), .SLOT_LEN(4), .SAMPLE_CYC(3)) dut (
    .CLK_50   (CLK_50),
    .RST      (RST),
    .CPU_A    (CPU_A),
    .CPU_nCS  (CPU_nCS),
    .CPU_nRD  (CPU_nRD),
    .CPU_D_OUT(CPU_D_OUT),
    .CPU_D_OE (CPU_D_OE),
    .CPU_nWAIT(CPU_nWAIT),
    .SLOT     (SLOT),
    .RAM_REQ  (RAM_REQ),
    .RAM_A    (RAM_A),
    .RAM_D_IN (RAM_D_IN),
    .RAM_nOE  (RAM_nOE)
  );

  task automatic tick();
    @(posedge CLK_50);
    #1;
    cyc++;
    if (slot_auto) SLOT = (cyc % 8 == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_nwait(input logic exp, input int budget, input string tag);
    for (int i = 0; i < budget && CPU_nWAIT !== exp; i++) tick();
    chk(tag, CPU_nWAIT, exp);
  endtask

  task automatic start_read(input logic [14:0] a, input string tag);
    CPU_A = a; CPU_nCS = 1'b0; CPU_nRD = 1'b0;
    wait_nwait(1'b0, 8, tag);
  endtask

  task automatic release_rd();
    CPU_nCS = 1'b1; CPU_nRD = 1'b1;
  endtask

  // One manual slot: SLOT pulse, then four access cycles fed with d bytes (cycle 0 = d[7:0]).
  task automatic do_slot(input logic [31:0] d, input logic [14:0] a_exp, input int rel_at,
                         input string tag);
    SLOT = 1'b1;
    tick();
    SLOT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == rel_at) release_rd();
      chk({tag, "_req"}, RAM_REQ, 1'b1);
      chk({tag, "_noe"}, RAM_nOE, 1'b0);
      chk({tag, "_addr"}, RAM_A, a_exp);
      ram_d_drv = d[i*8 +: 8];
      tick();
    end
    chk({tag, "_req_end"}, RAM_REQ, 1'b0);
  endtask

  task automatic check_hold(input string tag);
    logic [7:0] e;
    chk({tag, "_nwait"}, CPU_nWAIT, 1'b1);
    chk({tag, "_oe"}, CPU_D_OE, 1'b1);
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_dout"}, CPU_D_OUT, e);
    end
  endtask

  int req_cnt;
  logic [7:0] hold_val;

  initial begin
    // reset with an active read request held on the bus
    CPU_nCS = 1'b0; CPU_nRD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_nwait", CPU_nWAIT, 1'b1);
      chk("rst_oe", CPU_D_OE, 1'b0);
      chk("rst_req", RAM_REQ, 1'b0);
    end
    chk("rst_noe", RAM_nOE, 1'b1);
    chk("rst_addr", RAM_A, 15'h0);
    chk("rst_dout", CPU_D_OUT, 8'h00);
    release_rd();
    RST = 1'b0;
    repeat (4) tick();
    chk("idle_nwait", CPU_nWAIT, 1'b1);

    // basic read; CPU_A moves after latching
    start_read(15'h1234, "basic_wait");
    CPU_A = 15'h5555;
    repeat (7) tick();
    chk("basic_nwait_held", CPU_nWAIT, 1'b0);
    sb.push_back(8'hA5);
    do_slot(32'hA5A5A5A5, 15'h1234, -1, "basic");
    check_hold("basic_hold");
    hold_val = CPU_D_OUT;
    SLOT = 1'b1; ram_d_drv = 8'h3C;
    tick();
    SLOT = 1'b0;
    repeat (2) begin
      tick();
      chk("hold_slot_ignored", RAM_REQ, 1'b0);
      chk("hold_stable", CPU_D_OUT, hold_val);
    end
    release_rd();
    repeat (2) tick();
    chk("hold_oe_still", CPU_D_OE, 1'b1);
    tick();
    chk("hold_oe_drop", CPU_D_OE, 1'b0);
    chk("hold_addr_kept", RAM_A, 15'h1234);

    // sample point: only slot cycle 3 is captured
    tick();
    start_read(15'h0ABC, "samp_wait");
    repeat (2) tick();
    sb.push_back(8'h22);
    do_slot(32'h22111111, 15'h0ABC, -1, "samp");
    check_hold("samp_hold");
    release_rd();
    repeat (4) tick();
    chk("samp_idle_oe", CPU_D_OE, 1'b0);

    // abort before any slot
    start_read(15'h0042, "abort_wait");
    release_rd();
    repeat (3) tick();
    chk("abort_nwait", CPU_nWAIT, 1'b1);
    req_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      SLOT = (i % 2 == 0);
      tick();
      req_cnt += int'(RAM_REQ);
    end
    SLOT = 1'b0;
    chk("abort_no_req", req_cnt, 0);
    chk("abort_oe", CPU_D_OE, 1'b0);
    chk("abort_nwait_idle", CPU_nWAIT, 1'b1);

    // release during slot cycle 1: slot completes, HOLD skipped
    start_read(15'h0300, "mid_wait");
    repeat (2) tick();
    do_slot(32'h44444444, 15'h0300, 1, "mid");
    chk("mid_oe", CPU_D_OE, 1'b0);
    chk("mid_nwait", CPU_nWAIT, 1'b1);
    repeat (3) tick();
    chk("mid_oe_later", CPU_D_OE, 1'b0);
    chk("mid_req_later", RAM_REQ, 1'b0);

    // reset in the middle of an access
    start_read(15'h0777, "rstacc_wait");
    repeat (2) tick();
    SLOT = 1'b1;
    tick();
    SLOT = 1'b0;
    chk("rstacc_req_on", RAM_REQ, 1'b1);
    ram_d_drv = 8'h77;
    tick();
    RST = 1'b1; release_rd();
    tick();
    chk("rstacc_req", RAM_REQ, 1'b0);
    chk("rstacc_dout", CPU_D_OUT, 8'h00);
    chk("rstacc_oe", CPU_D_OE, 1'b0);
    RST = 1'b0;
    repeat (3) tick();

    // back-to-back reads with free-running slots and a RAM model
    ram_model = 1'b1;
    slot_auto = 1'b1;
    req_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      logic [14:0] a;
      bit done;
      a = (r == 0) ? 15'h0000 : 15'h7FFF;
      sb.push_back(mem_f(a));
      CPU_A = a; CPU_nCS = 1'b0; CPU_nRD = 1'b0;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
        tick();
        req_cnt += int'(RAM_REQ);
        if (RAM_REQ) chk("b2b_addr", RAM_A, a);
        if (CPU_D_OE) done = 1;
      end
      chk("b2b_done", done, 1'b1);
      check_hold("b2b_hold");
      release_rd();
      done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
        tick();
        req_cnt += int'(RAM_REQ);
        if (!CPU_D_OE) done = 1;
      end
      chk("b2b_release", done, 1'b1);
      repeat (2) begin
        tick();
        req_cnt += int'(RAM_REQ);
      end
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      req_cnt += int'(RAM_REQ);
    end
    chk("b2b_req_cycles", req_cnt, 8);
    chk("b2b_sb_empty", sb.size(), 0);
    slot_auto = 1'b0;
    SLOT = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
